// File: rtl/tile_sequencer_if.sv
// ============================================================================
// tile_sequencer_if : job request, datapath status and datapath control
//                     signals of the tile sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface tile_sequencer_if #(
  parameter int KT_W = 8
);
  logic            start;
  logic [KT_W-1:0] num_tiles;
  logic            w_done;
  logic            if_done;
  logic            rd_nxt_inst;
  logic            clr_w;
  logic            clr_if;
  logic            w_buffer_read;
  logic            if_buffer_read;
  logic            switch;
  logic            first;
  logic            last;
  logic            busy;
  logic            done;

  // master: front end plus datapath status; slave: the sequencer itself
  modport master (
    output start, num_tiles, w_done, if_done, rd_nxt_inst,
    input  clr_w, clr_if, w_buffer_read, if_buffer_read,
           switch, first, last, busy, done
  );

  modport slave (
    input  start, num_tiles, w_done, if_done, rd_nxt_inst,
    output clr_w, clr_if, w_buffer_read, if_buffer_read,
           switch, first, last, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/tile_sequencer.sv
// ============================================================================
// tile_sequencer : control FSM that preloads weights, swaps them into the
//                  systolic array and streams input rows for each K-tile
// Revision 1.0
// ============================================================================
`default_nettype none

module tile_sequencer #(
  parameter int SYS_ROWS = 4,
  parameter int A_ROWS   = 6,
  parameter int KT_W     = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  tile_sequencer_if.slave bus
);

  // The row thresholds live in the datapath; only sanity-check them here.
  generate
    if (SYS_ROWS < 1 || A_ROWS < 1 || KT_W < 1) begin : g_bad_cfg
      $error("tile_sequencer: SYS_ROWS, A_ROWS and KT_W must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLR_W      = 3'd1,
    S_LOAD_W     = 3'd2,
    S_SWITCH     = 3'd3,
    S_CLR_STREAM = 3'd4,
    S_STREAM     = 3'd5,
    S_DRAIN      = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t          r_state;
  logic [KT_W-1:0] r_k;
  logic [KT_W-1:0] r_tile;
  logic            r_preload;

  logic w_last_tile;
  logic w_next_pre;
  logic w_stream_exit;

  assign w_last_tile   = (r_tile == (r_k - KT_W'(1)));
  // Extended by one bit so tile+1 cannot wrap in the compare.
  assign w_next_pre    = (({1'b0, r_tile} + {{KT_W{1'b0}}, 1'b1}) < {1'b0, r_k});
  assign w_stream_exit = bus.if_done && (!r_preload || bus.w_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_tile    <= '0;
      r_preload <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_k       <= (bus.num_tiles == '0) ? KT_W'(1) : bus.num_tiles;
            r_tile    <= '0;
            r_preload <= 1'b0;
            r_state   <= S_CLR_W;
          end
        end
        S_CLR_W:  r_state <= S_LOAD_W;
        S_LOAD_W: begin
          if (bus.w_done) r_state <= S_SWITCH;
        end
        S_SWITCH: r_state <= S_CLR_STREAM;
        S_CLR_STREAM: begin
          r_preload <= w_next_pre;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          if (w_stream_exit) begin
            if (w_last_tile) begin
              r_state <= S_DRAIN;
            end else begin
              r_tile  <= r_tile + KT_W'(1);
              r_state <= S_SWITCH;
            end
          end
        end
        S_DRAIN: begin
          if (bus.rd_nxt_inst) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state plus the two counter flags.
  always_comb begin
    bus.clr_w          = 1'b0;
    bus.clr_if         = 1'b0;
    bus.w_buffer_read  = 1'b0;
    bus.if_buffer_read = 1'b0;
    bus.switch         = 1'b0;
    bus.first          = 1'b0;
    bus.last           = 1'b0;
    bus.busy           = (r_state != S_IDLE);
    bus.done           = 1'b0;
    case (r_state)
      S_CLR_W:  bus.clr_w = 1'b1;
      S_LOAD_W: bus.w_buffer_read = !bus.w_done;
      S_SWITCH: bus.switch = 1'b1;
      S_CLR_STREAM: begin
        bus.clr_if = 1'b1;
        bus.clr_w  = w_next_pre;
      end
      S_STREAM: begin
        bus.if_buffer_read = !bus.if_done;
        bus.w_buffer_read  = r_preload && !bus.w_done;
        bus.first          = (r_tile == '0);
        bus.last           = w_last_tile;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_sequencer.sv
// ============================================================================
// tb_tile_sequencer : vector table of jobs against a counter model of the
//                     datapath, with a scoreboard of expected switch cycles
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_tile_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tile_sequencer_if #(.KT_W(8)) bus ();

  tile_sequencer #(.SYS_ROWS(4), .A_ROWS(6), .KT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Datapath counter model; thresholds are changeable per job.
  int R_cur = 4;
  int M_cur = 6;
  int w_cnt;
  int if_cnt;
  logic frc = 1'b1;
  logic frc_w = 1'b0;
  logic frc_i = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cnt  <= 0;
      if_cnt <= 0;
    end else begin
      if (bus.clr_w)              w_cnt  <= 0;
      else if (bus.w_buffer_read) w_cnt  <= w_cnt + 1;
      if (bus.clr_if)              if_cnt <= 0;
      else if (bus.if_buffer_read) if_cnt <= if_cnt + 1;
    end
  end

  assign bus.w_done  = frc ? frc_w : (w_cnt >= R_cur);
  assign bus.if_done = frc ? frc_i : (if_cnt >= M_cur);

  typedef struct {
    int nt; int r; int m; int rd_at; bit inj;
    int e_sw; int e_wr; int e_ir; int e_first; int e_last;
    int e_both; int e_coinc; int e_clrw; int e_done;
  } vec_t;

  vec_t vecs[5];
  int   sw_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.clr_w, bus.clr_if, bus.w_buffer_read, bus.if_buffer_read,
            bus.switch, bus.first, bus.last, bus.busy, bus.done};
  endfunction

  task automatic run_job(input vec_t v, input int id);
    int cyc, k, mx, sw_exp;
    int n_sw, n_wr, n_ir, n_first, n_last, n_both, n_coinc, n_clrw, n_done;
    int done_cyc;
    string tag;
    tag = $sformatf("v%0d", id);
    n_sw = 0; n_wr = 0; n_ir = 0; n_first = 0; n_last = 0;
    n_both = 0; n_coinc = 0; n_clrw = 0; n_done = 0; done_cyc = -1;
    R_cur = v.r;
    M_cur = v.m;
    k  = (v.nt == 0) ? 1 : v.nt;
    mx = (v.r > v.m) ? v.r : v.m;
    for (int t = 0; t < k; t++) sw_q.push_back(v.r + 3 + t * (mx + 3));

    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_tiles   = 8'(v.nt);
    bus.rd_nxt_inst = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, " clr_w_cycle1"}, int'(bus.clr_w), 1);
      chk({tag, $sformatf(" busy_c%0d", cyc)}, int'(bus.busy), (cyc <= v.e_done) ? 1 : 0);
      if (bus.switch) begin
        n_sw++;
        if (sw_q.size() == 0) begin
          chk({tag, " extra_switch_cycle"}, cyc, -1);
        end else begin
          sw_exp = sw_q.pop_front();
          chk({tag, " switch_cycle"}, cyc, sw_exp);
        end
      end
      if (bus.w_buffer_read)  n_wr++;
      if (bus.if_buffer_read) n_ir++;
      if (bus.first)          n_first++;
      if (bus.last)           n_last++;
      if (bus.first && bus.last) n_both++;
      if (bus.clr_w)          n_clrw++;
      if (bus.clr_w && bus.clr_if) n_coinc++;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      bus.rd_nxt_inst = (cyc >= v.rd_at) && (done_cyc < 0);
      bus.start       = v.inj && (cyc == v.r + 6 || cyc == v.e_done);
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(posedge clk);
      #1 cyc++;
    end
    bus.start       = 1'b0;
    bus.rd_nxt_inst = 1'b0;
    if (done_cyc < 0) chk({tag, " timeout_no_done"}, cyc, -1);
    chk({tag, " done_cycle"},     done_cyc, v.e_done);
    chk({tag, " done_pulses"},    n_done,   1);
    chk({tag, " switch_count"},   n_sw,     v.e_sw);
    chk({tag, " w_reads"},        n_wr,     v.e_wr);
    chk({tag, " if_reads"},       n_ir,     v.e_ir);
    chk({tag, " first_cycles"},   n_first,  v.e_first);
    chk({tag, " last_cycles"},    n_last,   v.e_last);
    chk({tag, " first_and_last"}, n_both,   v.e_both);
    chk({tag, " clr_w_with_if"},  n_coinc,  v.e_coinc);
    chk({tag, " clr_w_count"},    n_clrw,   v.e_clrw);
    chk({tag, " switch_pending"}, sw_q.size(), 0);
    sw_q.delete();
  endtask

  initial begin
    //          nt R  M  rd  inj sw wr ir  f  l  b  co cw done
    vecs[0] = '{1, 4, 6, 19, 1'b0, 1,  4,  6, 7, 7, 7, 0, 1, 20};
    vecs[1] = '{3, 4, 6, 37, 1'b1, 3, 12, 18, 7, 7, 0, 2, 3, 38};
    vecs[2] = '{0, 4, 6, 19, 1'b0, 1,  4,  6, 7, 7, 7, 0, 1, 20};
    vecs[3] = '{2, 8, 6, 29, 1'b0, 2, 16, 12, 9, 7, 0, 1, 2, 32};
    vecs[4] = '{1, 8, 6, 21, 1'b0, 1,  8,  6, 7, 7, 7, 0, 1, 22};

    bus.start       = 1'b0;
    bus.num_tiles   = '0;
    bus.rd_nxt_inst = 1'b0;

    // Reset held with random inputs: every output must stay low.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.start       = 1'($urandom);
      bus.num_tiles   = 8'($urandom);
      bus.rd_nxt_inst = 1'($urandom);
      frc_w           = 1'($urandom);
      frc_i           = 1'($urandom);
      #1 chk($sformatf("reset_outs_%0d", i), int'(outs()), 0);
    end
    @(negedge clk);
    bus.start       = 1'b0;
    bus.rd_nxt_inst = 1'b0;
    frc             = 1'b0;
    rst             = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_job(vecs[i], i);

    // Reset during LOAD_W abandons the job; a fresh job must run cleanly.
    R_cur = 4;
    M_cur = 6;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_tiles = 8'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midreset_loading", int'(bus.w_buffer_read), 1);
    #2 rst = 1'b0;
    #1 chk("midreset_async_outs", int'(outs()), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midreset_hold_%0d", i), int'(outs()), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midreset_idle_%0d", i), int'(outs()), 0);
    end
    run_job(vecs[0], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tile_sequencer.md
# tile_sequencer

Control FSM that sequences one output tile through the `datapath` block. It preloads weights, swaps them into the systolic array, and streams input-feature rows. For multi-tile reductions it overlaps each next weight preload with the current stream. It drives `first`/`last` to the accumulator and reports completion once the accumulator signals `rd_nxt_inst`. It sits between the instruction/DMA front end and `datapath`, and owns every control input of `datapath`.

## Interface
- SYS_ROWS, default sys_rows (Config): weight rows per tile. Must match the datapath `w_done` threshold.
- A_ROWS, default A_rows (Config): input rows per tile. Must match the datapath `if_done` threshold.
- KT_W, default 8: width of the tile-count field.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run a job; sampled only in IDLE.
- num_tiles  in  KT_W  number of K-tiles to accumulate; sampled with `start`. A value of 0 is treated as 1.
- w_done  in  1  from datapath: weight counter has reached SYS_ROWS.
- if_done  in  1  from datapath: input counter has reached A_ROWS.
- rd_nxt_inst  in  1  from datapath: accumulator has finished, result is readable.
- clr_w  out  1  clears the datapath weight counter.
- clr_if  out  1  clears the datapath input counter.
- w_buffer_read  out  1  pops one weight row.
- if_buffer_read  out  1  pops one input row.
- switch  out  1  one-cycle swap of shadow weights into the active array.
- first  out  1  accumulator start flag.
- last  out  1  accumulator final-tile flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle job-complete pulse.

## Operation
- Registered state: FSM state, `k` (latched tile count, KT_W bits), `tile` (current tile index, KT_W bits), `preload` flag.
- Outputs are decoded from state, `tile`, `preload`, `w_done` and `if_done`. There are no other combinational paths from inputs to outputs.

States and transitions:
- IDLE: on `start`, latch k = max(num_tiles, 1), set tile = 0, go to CLR_W.
- CLR_W: `clr_w` = 1; go to LOAD_W.
- LOAD_W: `w_buffer_read` = !w_done. When `w_done` is high, go to SWITCH.
- SWITCH: `switch` = 1 for exactly one cycle; go to CLR_STREAM.
- CLR_STREAM: `clr_if` = 1. Set preload = (tile+1 < k). If preload, also assert `clr_w` in this same cycle. Go to STREAM.
- STREAM:
  - `if_buffer_read` = !if_done.
  - `w_buffer_read` = preload && !w_done.
  - `first` = (tile == 0); `last` = (tile == k-1). Both are held for the whole state.
  - Exit when if_done && (!preload || w_done). If tile == k-1, go to DRAIN; otherwise increment tile and go to SWITCH.
- DRAIN: wait for `rd_nxt_inst`. If it is already high on entry, it counts immediately. Go to DONE.
- DONE: `done` = 1 for one cycle; go to IDLE.

Rules:
- Every output is 0 in IDLE and in any state where it is not listed above.
- `start` outside IDLE is ignored; it is not queued.
- k = 1 means no preload occurs, and `first` and `last` are both high during the single STREAM.
- Tile arithmetic is unsigned KT_W-bit. Since k ≤ 2^KT_W−1, `tile` never wraps.

## Timing
- While `rst` is low: state = IDLE, k = tile = preload = 0, and every output is 0 immediately. Asserting reset mid-job abandons the job with no `done` pulse.
- Numbering: `start` is sampled at edge 0, so CLR_W occupies cycle 1.
- With k = 1, R = SYS_ROWS, M = A_ROWS:
  - LOAD_W: cycles 2..R+2, with reads on cycles 2..R+1 (exactly R reads).
  - SWITCH: cycle R+3.
  - CLR_STREAM: cycle R+4.
  - STREAM: reads on R+5..R+M+4 (exactly M reads); `if_done` is seen at cycle R+M+5.
  - DRAIN is entered at cycle R+M+6.
  - `done` is asserted in the cycle after `rd_nxt_inst` is seen in DRAIN.
- Each additional tile adds max(M, R) + 3 cycles: STREAM, SWITCH, CLR_STREAM.
- Exactly one `switch` pulse per tile, always in the cycle after both `if_done` and (if preloading) `w_done` are satisfied.
- If `w_done` and `if_done` rise in the same cycle, STREAM exits that cycle.
- `busy` falls in the cycle after DONE.

## Test plan
- Reset: hold rst = 0 with random inputs → all outputs 0, busy = 0; release, then start → clr_w pulses on cycle 1.
- R=4, M=6, num_tiles=1 → 4 w_buffer_read, 1 switch (cycle 7), 6 if_buffer_read, first = last = 1 throughout STREAM; rd_nxt_inst 3 cycles after DRAIN entry → single done pulse.
- num_tiles=3 → 3 switch pulses, 12 weight reads, 18 input reads; first only in tile 0, last only in tile 2; clr_w coincides with clr_if in tiles 0 and 1 only.
- num_tiles=0 → identical trace to num_tiles=1.
- R=8 > M=6 with preload → STREAM lasts until w_done (8 reads), if_buffer_read drops after 6 reads, switch follows w_done by one cycle.
- start pulsed during STREAM and DONE → ignored. rst asserted mid-LOAD_W → outputs 0 asynchronously, no done; the next start runs a full clean job.
